// File: rtl/pwm_pkg.sv
// rtl/pwm_pkg.sv - shared constants and helpers for the multi-channel PWM
package pwm_pkg;

  localparam logic MODE_EDGE   = 1'b0;
  localparam logic MODE_CENTER = 1'b1;
  localparam logic DIR_UP      = 1'b0;
  localparam logic DIR_DOWN    = 1'b1;

  function automatic int ch_idx_w(input int num_ch);
    return (num_ch > 1) ? $clog2(num_ch) : 1;
  endfunction

endpackage

// File: rtl/pwm_timebase.sv
// rtl/pwm_timebase.sv - prescaled edge/center counter with period-boundary reload
module pwm_timebase
  import pwm_pkg::*;
#(
  parameter int _NUM_BIT   = 12,
  parameter int _PRESC_BIT = 8
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  i_enable,
  input  logic                  i_center,
  input  logic [_PRESC_BIT-1:0] i_prescale,
  input  logic [_NUM_BIT-1:0]   i_top,
  output logic [_NUM_BIT-1:0]   o_cnt,
  output logic                  o_boundary,
  output logic                  o_period
);

  logic [_PRESC_BIT-1:0] presc_q, presc_d;
  logic [_NUM_BIT-1:0]   cnt_q, cnt_d;
  logic [_NUM_BIT-1:0]   top_q, top_d;
  logic                  dir_q, dir_d;
  logic                  mode_q, mode_d;
  logic                  en_q;
  logic                  period_q;
  logic                  boundary;
  logic                  tick;

  always_comb begin
    presc_d  = presc_q;
    cnt_d    = cnt_q;
    dir_d    = dir_q;
    top_d    = top_q;
    mode_d   = mode_q;
    boundary = 1'b0;
    // >= so a prescale lowered below the running count ticks at once
    tick     = (presc_q >= i_prescale);
    if (!i_enable) begin
      presc_d = '0;
      cnt_d   = '0;
      dir_d   = DIR_UP;
    end else if (!en_q) begin
      boundary = 1'b1;
    end else begin
      presc_d = tick ? '0 : presc_q + _PRESC_BIT'(1);
      if (tick) begin
        if (mode_q == MODE_CENTER && top_q != '0) begin
          if (dir_q == DIR_UP) begin
            if (cnt_q >= top_q) begin
              dir_d = DIR_DOWN;
              cnt_d = cnt_q - _NUM_BIT'(1);
            end else begin
              cnt_d = cnt_q + _NUM_BIT'(1);
            end
          end else begin
            cnt_d = cnt_q - _NUM_BIT'(1);
            if (cnt_q == _NUM_BIT'(1)) boundary = 1'b1;
          end
        end else if (cnt_q >= top_q) begin
          cnt_d    = '0;
          boundary = 1'b1;
        end else begin
          cnt_d = cnt_q + _NUM_BIT'(1);
        end
      end
    end
    if (boundary) begin
      top_d  = i_top;
      mode_d = i_center;
      dir_d  = DIR_UP;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      presc_q  <= '0;
      cnt_q    <= '0;
      dir_q    <= DIR_UP;
      top_q    <= '0;
      mode_q   <= MODE_EDGE;
      en_q     <= 1'b0;
      period_q <= 1'b0;
    end else begin
      presc_q  <= presc_d;
      cnt_q    <= cnt_d;
      dir_q    <= dir_d;
      top_q    <= top_d;
      mode_q   <= mode_d;
      en_q     <= i_enable;
      period_q <= boundary;
    end
  end

  assign o_cnt      = cnt_q;
  assign o_boundary = boundary;
  assign o_period   = period_q;

endmodule

// File: rtl/pwm_multi.sv
// rtl/pwm_multi.sv - multi-channel PWM with double-buffered duty over a shared timebase
module pwm_multi
  import pwm_pkg::*;
#(
  parameter int _NUM_BIT   = 12,
  parameter int _NUM_CH    = 4,
  parameter int _PRESC_BIT = 8
) (
  input  logic                          i_clk,
  input  logic                          i_rst_n,
  input  logic                          i_enable,
  input  logic                          i_center,
  input  logic [_PRESC_BIT-1:0]         i_prescale,
  input  logic [_NUM_BIT-1:0]           i_top,
  input  logic                          i_wr,
  input  logic [ch_idx_w(_NUM_CH)-1:0]  i_wr_ch,
  input  logic [_NUM_BIT-1:0]           i_wr_duty,
  output logic [_NUM_CH-1:0]            o_pwm,
  output logic                          o_period
);

  localparam int CHW = ch_idx_w(_NUM_CH);

  logic [_NUM_BIT-1:0] cnt;
  logic                boundary;
  logic [_NUM_CH-1:0]  pwm_d, pwm_q;

  pwm_timebase #(
    ._NUM_BIT   (_NUM_BIT),
    ._PRESC_BIT (_PRESC_BIT)
  ) u_timebase (
    .i_clk      (i_clk),
    .i_rst_n    (i_rst_n),
    .i_enable   (i_enable),
    .i_center   (i_center),
    .i_prescale (i_prescale),
    .i_top      (i_top),
    .o_cnt      (cnt),
    .o_boundary (boundary),
    .o_period   (o_period)
  );

  for (genvar ch = 0; ch < _NUM_CH; ch++) begin : g_ch
    logic [_NUM_BIT-1:0] shadow_q, shadow_d;
    logic [_NUM_BIT-1:0] active_q, active_d;
    logic                hit;

    // Out-of-range indices match no channel, so those writes drop silently
    always_comb begin
      hit      = i_wr && (i_wr_ch == CHW'(ch));
      shadow_d = hit ? i_wr_duty : shadow_q;
      active_d = boundary ? shadow_d : active_q;
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
        shadow_q <= '0;
        active_q <= '0;
      end else begin
        shadow_q <= shadow_d;
        active_q <= active_d;
      end
    end

    assign pwm_d[ch] = i_enable && (cnt < active_q);
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) pwm_q <= '0;
    else          pwm_q <= pwm_d;
  end

  assign o_pwm = pwm_q;

endmodule

// File: tb/tb_pwm_multi.sv
// tb/tb_pwm_multi.sv - scoreboard bench for pwm_multi measuring high time and period per window
module tb_pwm_multi;

  localparam int NB = 12;
  localparam int NC = 3;
  localparam int NP = 8;

  logic          clk = 1'b0;
  logic          rst_n, en, center, wr;
  logic [NP-1:0] presc;
  logic [NB-1:0] top, wduty;
  logic [1:0]    wch;
  logic [NC-1:0] pwm;
  logic          period;

  int n_chk  = 0;
  int n_pass = 0;

  typedef struct {
    string tag;
    int    val;
  } exp_t;
  exp_t sb[$];

  always #5 clk = ~clk;

  pwm_multi #(
    ._NUM_BIT   (NB),
    ._NUM_CH    (NC),
    ._PRESC_BIT (NP)
  ) dut (
    .i_clk      (clk),
    .i_rst_n    (rst_n),
    .i_enable   (en),
    .i_center   (center),
    .i_prescale (presc),
    .i_top      (top),
    .i_wr       (wr),
    .i_wr_ch    (wch),
    .i_wr_duty  (wduty),
    .o_pwm      (pwm),
    .o_period   (period)
  );

  task automatic check_eq(input string tag, input int obs, input int exp);
    n_chk++;
    if (obs == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
  endtask

  task automatic expect_win(input string tag, input int hi, input int per);
    exp_t e;
    e.tag = {tag, "_hi"};
    e.val = hi;
    sb.push_back(e);
    e.tag = {tag, "_per"};
    e.val = per;
    sb.push_back(e);
  endtask

  task automatic wr_duty(input int ch, input int duty);
    @(negedge clk);
    wr    = 1'b1;
    wch   = 2'(ch);
    wduty = NB'(duty);
    @(negedge clk);
    wr    = 1'b0;
  endtask

  task automatic wait_pulse(input string tag);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!period && n < 200);
    check_eq(tag, int'(period), 1);
  endtask

  // Starts on a sample showing o_period; counts highs up to and including the next pulse
  task automatic run_win(input int ch, input int wr_at = -1, input int ch_w = 0, input int duty_w = 0);
    int   hi  = 0;
    int   per = 0;
    exp_t e;
    do begin
      @(negedge clk);
      per++;
      if (pwm[ch]) hi++;
      wr = (per == wr_at);
      if (wr) begin
        wch   = 2'(ch_w);
        wduty = NB'(duty_w);
      end
    end while (!period && per < 200);
    wr = 1'b0;
    if (sb.size() < 2) begin
      check_eq("sb_underflow", sb.size(), 2);
    end else begin
      e = sb.pop_front();
      check_eq(e.tag, hi, e.val);
      e = sb.pop_front();
      check_eq(e.tag, per, e.val);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    rst_n  = 1'b0;
    en     = 1'b0;
    center = 1'b0;
    presc  = '0;
    top    = NB'(9);
    wr     = 1'b0;
    wch    = '0;
    wduty  = '0;
    repeat (3) @(negedge clk);
    check_eq("rst_pwm", int'(pwm), 0);
    check_eq("rst_period", int'(period), 0);
    rst_n = 1'b1;

    wr_duty(0, 3);
    expect_win("t1", 3, 10);
    @(negedge clk);
    en = 1'b1;
    wait_pulse("t1_sync");
    run_win(0);

    expect_win("t1_lowtop", 3, 10);
    expect_win("t1_newtop", 3, 4);
    fork
      begin
        repeat (5) @(negedge clk);
        top = NB'(3);
      end
    join_none
    run_win(0);
    run_win(0);

    top   = NB'(4);
    presc = NP'(3);
    wr_duty(0, 2);
    expect_win("t2", 8, 20);
    wait_pulse("t2_sync");
    run_win(0);

    presc  = '0;
    center = 1'b1;
    top    = NB'(8);
    wr_duty(0, 3);
    expect_win("t3", 5, 16);
    wait_pulse("t3_sync");
    run_win(0);

    center = 1'b0;
    top    = NB'(9);
    wr_duty(0, 0);
    wr_duty(1, 10);
    wr_duty(2, 4095);
    expect_win("t5_d0", 0, 10);
    expect_win("t5_dtop1", 10, 10);
    expect_win("t5_dmax", 10, 10);
    wait_pulse("t5_sync");
    run_win(0);
    run_win(1);
    run_win(2);

    wr_duty(3, 5);
    expect_win("t5_badch0", 0, 10);
    expect_win("t5_badch1", 10, 10);
    expect_win("t5_badch2", 10, 10);
    wait_pulse("t5_sync2");
    run_win(0);
    run_win(1);
    run_win(2);

    wr_duty(0, 2);
    expect_win("t4_old", 2, 10);
    expect_win("t4_mid", 7, 10);
    expect_win("t4_bnd", 4, 10);
    wait_pulse("t4_sync");
    run_win(0, 3, 0, 7);
    run_win(0, 9, 0, 4);
    run_win(0);

    repeat (3) @(negedge clk);
    check_eq("pre_dis_pwm1", int'(pwm[1]), 1);
    en = 1'b0;
    @(negedge clk);
    check_eq("dis_pwm", int'(pwm), 0);
    check_eq("dis_period", int'(period), 0);
    wr_duty(0, 5);
    repeat (3) @(negedge clk);
    check_eq("dis_hold_pwm", int'(pwm), 0);
    en = 1'b1;
    @(negedge clk);
    check_eq("reen_period", int'(period), 1);
    expect_win("t6_reen", 5, 10);
    run_win(0);

    repeat (4) @(negedge clk);
    check_eq("pre_rst_pwm1", int'(pwm[1]), 1);
    #2 rst_n = 1'b0;
    #1;
    check_eq("rst_async_pwm", int'(pwm), 0);
    check_eq("rst_async_period", int'(period), 0);
    @(negedge clk);
    rst_n = 1'b1;
    expect_win("t6_rst", 0, 10);
    wait_pulse("t6_rst_sync");
    run_win(1);

    check_eq("sb_drained", sb.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
